// File: rtl/vram_plane_ctrl_pkg.sv
// Shared types and constants for the VRAM plane controller: FSM states,
// default I/O port map and the plane read-combine helper.
package vram_plane_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  localparam int          DEF_PLANES     = 6;
  localparam int          DEF_AW         = 13;
  localparam logic [15:0] DEF_VRAM_BASE  = 16'hEC00;
  localparam logic [7:0]  DEF_IO_RD_BANK = 8'hF1;
  localparam logic [7:0]  DEF_IO_WR_BANK = 8'hF2;
  localparam logic [7:0]  DEF_IO_CTRL    = 8'hFB;
  localparam logic [7:0]  DEF_IO_IRQ_ACK = 8'hFC;

  // q holds up to eight planes, plane i at [8i+7:8i]; mask is already
  // limited to the planes that exist. mode 0 ORs, mode 1 takes the lowest.
  function automatic logic [7:0] plane_combine(input logic [63:0] q,
                                               input logic [7:0]  mask,
                                               input logic        mode);
    logic [7:0] acc;
    logic       found;
    acc   = 8'h00;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (!mode) begin
          acc = acc | q[8*i +: 8];
        end else if (!found) begin
          acc   = q[8*i +: 8];
          found = 1'b1;
        end else begin
          acc = acc;
        end
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/vram_plane_ctrl_if.sv
// Z80-side bus seen by the VRAM plane controller.
interface vram_plane_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr_n;
  logic        cpu_rd_n;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic [7:0]  cpu_din;
  logic        cpu_wait_n;
  logic        cpu_int_n;

  modport master (
    output cpu_addr, cpu_dout, cpu_wr_n, cpu_rd_n, cpu_mreq_n, cpu_iorq_n,
    input  cpu_din, cpu_wait_n, cpu_int_n
  );

  modport slave (
    input  cpu_addr, cpu_dout, cpu_wr_n, cpu_rd_n, cpu_mreq_n, cpu_iorq_n,
    output cpu_din, cpu_wait_n, cpu_int_n
  );
endinterface

// File: rtl/vram_plane_ctrl_vblank_irq.sv
// Vertical-blank interrupt: rising-edge detect, pending latch held until
// acknowledged, and the maskable enable bit.
module vblank_irq (
  input  logic clk,
  input  logic reset_n,
  input  logic vb,
  input  logic ack,
  input  logic en_we,
  input  logic en_d,
  output logic pend,
  output logic irq_en,
  output logic int_n
);

  logic vb_prev_r;
  logic pend_r;
  logic irq_en_r;
  logic int_n_r;
  logic pend_nxt_s;
  logic en_nxt_s;

  // Next pending/enable values; a fresh edge wins over a same-cycle ack.
  always_comb begin
    pend_nxt_s = pend_r;
    en_nxt_s   = irq_en_r;
    if (vb && !vb_prev_r) begin
      pend_nxt_s = 1'b1;
    end else if (ack) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (en_we) begin
      en_nxt_s = en_d;
    end else begin
      en_nxt_s = irq_en_r;
    end
  end

  // Edge history, pending/enable state and registered interrupt line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vb_prev_r <= 1'b0;
      pend_r    <= 1'b0;
      irq_en_r  <= 1'b1;
      int_n_r   <= 1'b1;
    end else begin
      vb_prev_r <= vb;
      pend_r    <= pend_nxt_s;
      irq_en_r  <= en_nxt_s;
      int_n_r   <= ~(pend_nxt_s & en_nxt_s);
    end
  end

  assign pend   = pend_r;
  assign irq_en = irq_en_r;
  assign int_n  = int_n_r;

endmodule

// File: rtl/vram_plane_ctrl.sv
// Z80-to-VRAM plane controller: banked broadcast writes, wait-stated
// combined reads, I/O-mapped bank/mode registers and the vblank interrupt.
module vram_plane_ctrl
  import vram_plane_pkg::*;
#(
  parameter int          PLANES     = DEF_PLANES,
  parameter int          AW         = DEF_AW,
  parameter logic [15:0] VRAM_BASE  = DEF_VRAM_BASE,
  parameter logic [7:0]  IO_RD_BANK = DEF_IO_RD_BANK,
  parameter logic [7:0]  IO_WR_BANK = DEF_IO_WR_BANK,
  parameter logic [7:0]  IO_CTRL    = DEF_IO_CTRL,
  parameter logic [7:0]  IO_IRQ_ACK = DEF_IO_IRQ_ACK
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vram_plane_ctrl_if.slave      bus,
  input  logic                  vb,
  output logic [AW-1:0]         plane_addr,
  output logic [7:0]            plane_din,
  output logic [PLANES-1:0]     plane_we,
  input  logic [8*PLANES-1:0]   plane_q
);

  localparam logic [7:0] PLANE_MASK = 8'((32'd1 << PLANES) - 32'd1);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [7:0]          rd_bank_r;
  logic [7:0]          wr_bank_r;
  logic                mode_r;
  logic [AW-1:0]       plane_addr_r;
  logic [7:0]          plane_din_r;
  logic [PLANES-1:0]   plane_we_r;
  logic [7:0]          cpu_din_r;
  logic [7:0]          io_port_s;
  logic [7:0]          io_rdata_s;
  logic [63:0]         q_pad_s;
  logic                win_hit_s;
  logic                rd_hit_s;
  logic                wr_hit_s;
  logic                wr_start_s;
  logic                rd_start_s;
  logic                io_wr_s;
  logic                io_rd_s;
  logic                ack_s;
  logic                en_we_s;
  logic                pend_s;
  logic                irq_en_s;
  logic                int_n_s;

  assign io_port_s  = bus.cpu_addr[7:0];
  assign win_hit_s  = ~bus.cpu_mreq_n & (bus.cpu_addr >= VRAM_BASE);
  assign rd_hit_s   = win_hit_s & ~bus.cpu_rd_n;
  assign wr_hit_s   = win_hit_s & ~bus.cpu_wr_n;
  assign wr_start_s = (state_r == ST_IDLE) & wr_hit_s;
  assign rd_start_s = (state_r == ST_IDLE) & rd_hit_s & ~wr_hit_s;
  assign io_wr_s    = ~bus.cpu_iorq_n & ~bus.cpu_wr_n;
  assign io_rd_s    = ~bus.cpu_iorq_n & ~bus.cpu_rd_n;
  assign ack_s      = io_wr_s & (io_port_s == IO_IRQ_ACK);
  assign en_we_s    = io_wr_s & (io_port_s == IO_CTRL);
  assign q_pad_s    = 64'(plane_q);

  vblank_irq u_vblank_irq (
    .clk     (clk),
    .reset_n (reset_n),
    .vb      (vb),
    .ack     (ack_s),
    .en_we   (en_we_s),
    .en_d    (bus.cpu_dout[0]),
    .pend    (pend_s),
    .irq_en  (irq_en_s),
    .int_n   (int_n_s)
  );

  // Bank masks and read mode; bits for absent planes never stick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank_r <= 8'h00;
      wr_bank_r <= 8'h00;
      mode_r    <= 1'b0;
    end else begin
      if (io_wr_s && (io_port_s == IO_RD_BANK)) rd_bank_r <= bus.cpu_dout & PLANE_MASK;
      if (io_wr_s && (io_port_s == IO_WR_BANK)) wr_bank_r <= bus.cpu_dout & PLANE_MASK;
      if (en_we_s) mode_r <= bus.cpu_dout[1];
    end
  end

  // I/O read mux over the listed ports.
  always_comb begin
    io_rdata_s = 8'hFF;
    case (io_port_s)
      IO_RD_BANK: io_rdata_s = rd_bank_r;
      IO_WR_BANK: io_rdata_s = wr_bank_r;
      IO_CTRL:    io_rdata_s = {6'b000000, mode_r, irq_en_s};
      IO_IRQ_ACK: io_rdata_s = {7'b0000000, pend_s};
      default:    io_rdata_s = 8'hFF;
    endcase
  end

  // Access FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; HOLD waits for the strobe to drop so one strobe is one access.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_hit_s) begin
          state_nxt_s = ST_WR;
        end else if (rd_hit_s) begin
          state_nxt_s = ST_RD1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR:   state_nxt_s = ST_HOLD;
      ST_RD1:  state_nxt_s = ST_RD2;
      ST_RD2:  state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (bus.cpu_mreq_n) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Plane address/data/enable and CPU read data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plane_addr_r <= '0;
      plane_din_r  <= 8'h00;
      plane_we_r   <= '0;
      cpu_din_r    <= 8'h00;
    end else begin
      plane_we_r <= '0;
      if (wr_start_s) begin
        plane_addr_r <= bus.cpu_addr[AW-1:0];
        plane_din_r  <= bus.cpu_dout;
        plane_we_r   <= wr_bank_r[PLANES-1:0];
      end else if (rd_start_s) begin
        plane_addr_r <= bus.cpu_addr[AW-1:0];
      end
      if (state_r == ST_RD2) begin
        cpu_din_r <= plane_combine(q_pad_s, rd_bank_r, mode_r);
      end else if (io_rd_s) begin
        cpu_din_r <= io_rdata_s;
      end
    end
  end

  // Wait must drop in the detect cycle itself, before any register can react.
  assign bus.cpu_wait_n = ~(reset_n & (rd_start_s | (state_r == ST_RD1) | (state_r == ST_RD2)));
  assign bus.cpu_din    = cpu_din_r;
  assign bus.cpu_int_n  = int_n_s;
  assign plane_addr     = plane_addr_r;
  assign plane_din      = plane_din_r;
  assign plane_we       = plane_we_r;

endmodule

// File: tb/tb_vram_plane_ctrl.sv
// Scoreboard bench for vram_plane_ctrl: directed cases plus randomized
// bank/mode/write/read traffic checked against a plane-array reference model.
module tb_vram_plane_ctrl;

  localparam int PLANES = 6;
  localparam int AW     = 13;
  localparam logic [15:0] BASE = 16'hEC00;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                vb;
  logic [AW-1:0]       plane_addr;
  logic [7:0]          plane_din;
  logic [PLANES-1:0]   plane_we;
  logic [8*PLANES-1:0] plane_q;

  vram_plane_ctrl_if bus_if ();

  vram_plane_ctrl #(.PLANES(PLANES), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .vb         (vb),
    .plane_addr (plane_addr),
    .plane_din  (plane_din),
    .plane_we   (plane_we),
    .plane_q    (plane_q)
  );

  always #5 clk = ~clk;

  // Plane RAMs: one write port, registered read with one cycle of latency.
  logic [7:0] ram [PLANES][8192];
  logic [7:0] q_r [PLANES];
  always @(posedge clk) begin
    for (int p = 0; p < PLANES; p++) begin
      if (plane_we[p]) ram[p][plane_addr] <= plane_din;
      q_r[p] <= ram[p][plane_addr];
    end
  end
  always_comb begin
    plane_q = '0;
    for (int p = 0; p < PLANES; p++) plane_q[8*p +: 8] = q_r[p];
  end

  // Reference model state.
  logic [7:0] ref_mem [PLANES][8192];
  logic [7:0] rd_bank_m, wr_bank_m;
  logic       mode_m;
  logic [28:0] wr_q [$];
  logic [7:0]  rd_q [$];

  int checks = 0;
  int failures = 0;
  int we_pulses = 0;
  int wcnt = 0;
  bit rd_done = 1'b0;
  logic [28:0] exp_wr;
  logic [7:0]  exp_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_read(input logic [12:0] pa);
    logic [7:0] acc;
    acc = 8'h00;
    if (mode_m == 1'b0) begin
      for (int p = 0; p < PLANES; p++) if (rd_bank_m[p]) acc = acc | ref_mem[p][pa];
    end else begin
      for (int p = PLANES - 1; p >= 0; p--) if (rd_bank_m[p]) acc = ref_mem[p][pa];
    end
    return acc;
  endfunction

  // Monitor: pops expected writes on every plane_we pulse and expected
  // read data when a window read stops waiting.
  always @(negedge clk) begin
    if (reset_n) begin
      if (plane_we != '0) begin
        we_pulses++;
        if (wr_q.size() == 0) begin
          check("wr_unexpected_we", 32'(plane_we), 32'h0);
        end else begin
          exp_wr = wr_q.pop_front();
          check("wr_we",   32'(plane_we),   32'(exp_wr[28:21]));
          check("wr_addr", 32'(plane_addr), 32'(exp_wr[20:8]));
          check("wr_data", 32'(plane_din),  32'(exp_wr[7:0]));
        end
      end
      if (!bus_if.cpu_mreq_n && !bus_if.cpu_rd_n && bus_if.cpu_addr >= BASE) begin
        if (!bus_if.cpu_wait_n) begin
          wcnt++;
        end else if (!rd_done) begin
          rd_done = 1'b1;
          check("rd_wait_cycles", 32'(wcnt), 32'd3);
          if (rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected got=%0h exp=none", bus_if.cpu_din);
          end else begin
            exp_rd = rd_q.pop_front();
            check("rd_data", 32'(bus_if.cpu_din), 32'(exp_rd));
          end
        end
      end else begin
        wcnt    = 0;
        rd_done = 1'b0;
      end
    end else begin
      wcnt    = 0;
      rd_done = 1'b1;
    end
  end

  task automatic bus_idle();
    bus_if.cpu_mreq_n = 1'b1;
    bus_if.cpu_iorq_n = 1'b1;
    bus_if.cpu_rd_n   = 1'b1;
    bus_if.cpu_wr_n   = 1'b1;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    @(posedge clk); #1;
    bus_if.cpu_addr = {8'h00, port};
    bus_if.cpu_dout = d;
    bus_if.cpu_iorq_n = 1'b0;
    bus_if.cpu_wr_n = 1'b0;
    if (port == 8'hF1) rd_bank_m = d & 8'(2**PLANES - 1);
    if (port == 8'hF2) wr_bank_m = d & 8'(2**PLANES - 1);
    if (port == 8'hFB) mode_m = d[1];
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic io_read(input string name, input logic [7:0] port, input logic [7:0] exp);
    @(posedge clk); #1;
    bus_if.cpu_addr = {8'h00, port};
    bus_if.cpu_iorq_n = 1'b0;
    bus_if.cpu_rd_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check(name, 32'(bus_if.cpu_din), 32'(exp));
    bus_idle();
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    if (a >= BASE) begin
      for (int p = 0; p < PLANES; p++) if (wr_bank_m[p]) ref_mem[p][a[12:0]] = d;
      if (wr_bank_m != 8'h00) wr_q.push_back({wr_bank_m, a[12:0], d});
    end
    @(posedge clk); #1;
    bus_if.cpu_addr = a;
    bus_if.cpu_dout = d;
    bus_if.cpu_mreq_n = 1'b0;
    bus_if.cpu_wr_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic mem_read(input logic [15:0] a);
    int n;
    if (a >= BASE) rd_q.push_back(ref_read(a[12:0]));
    @(posedge clk); #1;
    bus_if.cpu_addr = a;
    bus_if.cpu_mreq_n = 1'b0;
    bus_if.cpu_rd_n = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.cpu_wait_n && n < 12);
    if (a >= BASE) check("rd_complete", 32'(bus_if.cpu_wait_n), 32'd1);
    else check("outwin_no_wait", 32'(n), 32'd1);
    @(posedge clk); #1;
    bus_idle();
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = ($urandom_range(0, 1) == 0) ? 16'hEC00 : 16'hFFF0;
    return a + 16'($urandom_range(0, 15));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int p0;
    for (int p = 0; p < PLANES; p++)
      for (int a = 0; a < 8192; a++) ref_mem[p][a] = 8'h00;
    rd_bank_m = 8'h00; wr_bank_m = 8'h00; mode_m = 1'b0;
    reset_n = 1'b0;
    vb = 1'b0;
    bus_if.cpu_addr = 16'h0000;
    bus_if.cpu_dout = 8'h00;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_din",   32'(bus_if.cpu_din),    32'h0);
    check("rst_wait",  32'(bus_if.cpu_wait_n), 32'h1);
    check("rst_int",   32'(bus_if.cpu_int_n),  32'h1);
    check("rst_we",    32'(plane_we),          32'h0);
    check("rst_paddr", 32'(plane_addr),        32'h0);
    check("rst_pdin",  32'(plane_din),         32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Broadcast write to planes 0 and 2, register readback.
    io_write(8'hF2, 8'h05);
    io_read("io_wr_bank", 8'hF2, 8'h05);
    io_read("io_ctrl", 8'hFB, 8'h01);
    io_read("io_other", 8'h10, 8'hFF);
    mem_write(16'hEC10, 8'hA5, 2);

    // Prefill every address the random phase uses.
    io_write(8'hF2, 8'h3F);
    for (int i = 0; i < 16; i++) begin
      mem_write(16'hEC00 + 16'(i), 8'h00, 2);
      mem_write(16'hFFF0 + 16'(i), 8'h00, 2);
    end

    // Combine modes over planes 0 and 2.
    io_write(8'hF2, 8'h01); mem_write(16'hEC10, 8'h0F, 2);
    io_write(8'hF2, 8'h04); mem_write(16'hEC10, 8'hF0, 2);
    io_write(8'hF1, 8'h05);
    io_write(8'hFB, 8'h01); mem_read(16'hEC10);
    io_write(8'hFB, 8'h03); mem_read(16'hEC10);
    io_write(8'hF1, 8'hC0); mem_read(16'hEC10);
    p0 = we_pulses;
    io_write(8'hF2, 8'hC0); mem_write(16'hEC11, 8'h77, 3);
    check("wr_bank_absent_planes", 32'(we_pulses - p0), 32'd0);
    p0 = we_pulses;
    io_write(8'hF2, 8'h12); mem_write(16'hFFF3, 8'h5A, 10);
    check("held_wr_pulses", 32'(we_pulses - p0), 32'd1);
    p0 = we_pulses;
    mem_write(16'hEBFF, 8'h33, 2);
    check("outwin_wr_pulses", 32'(we_pulses - p0), 32'd0);
    mem_read(16'hEBFF);

    // Interrupt: edge, edge-vs-ack, plain ack, masking.
    @(posedge clk); #1; vb = 1'b1;
    @(negedge clk); check("irq_not_early", 32'(bus_if.cpu_int_n), 32'h1);
    @(negedge clk); check("irq_set", 32'(bus_if.cpu_int_n), 32'h0);
    @(posedge clk); #1; vb = 1'b0;
    io_write(8'hFC, 8'h00);
    @(negedge clk); check("irq_ack", 32'(bus_if.cpu_int_n), 32'h1);
    @(posedge clk); #1; vb = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; vb = 1'b0;
    @(posedge clk); #1;
    vb = 1'b1;
    bus_if.cpu_addr = 16'h00FC; bus_if.cpu_iorq_n = 1'b0; bus_if.cpu_wr_n = 1'b0;
    @(posedge clk); #1; bus_idle();
    @(negedge clk); check("irq_edge_beats_ack", 32'(bus_if.cpu_int_n), 32'h0);
    io_write(8'hFC, 8'h00);
    @(negedge clk); check("irq_ack2", 32'(bus_if.cpu_int_n), 32'h1);
    io_write(8'hFB, {6'b000000, mode_m, 1'b0});
    @(posedge clk); #1; vb = 1'b0;
    @(posedge clk); #1; vb = 1'b1;
    @(negedge clk); @(negedge clk); check("irq_masked", 32'(bus_if.cpu_int_n), 32'h1);
    io_write(8'hFB, {6'b000000, mode_m, 1'b1});
    @(negedge clk); check("irq_unmasked", 32'(bus_if.cpu_int_n), 32'h0);
    @(posedge clk); #1; vb = 1'b0;
    io_write(8'hFC, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: io_write(8'hF1, 8'($urandom));
        1: io_write(8'hF2, 8'($urandom));
        2: io_write(8'hFB, {6'b000000, 1'($urandom), 1'b1});
        3: mem_write(rand_addr(), 8'($urandom), $urandom_range(2, 5));
        default: mem_read(rand_addr());
      endcase
    end

    // Reset in the middle of a read, with vb already high at release.
    @(posedge clk); #1;
    bus_if.cpu_addr = 16'hEC10; bus_if.cpu_mreq_n = 1'b0; bus_if.cpu_rd_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_wait", 32'(bus_if.cpu_wait_n), 32'h1);
    check("midrst_paddr", 32'(plane_addr), 32'h0);
    check("midrst_din", 32'(bus_if.cpu_din), 32'h0);
    vb = 1'b1;
    rd_bank_m = 8'h00; wr_bank_m = 8'h00; mode_m = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk); check("irq_vb_at_release", 32'(bus_if.cpu_int_n), 32'h0);
    mem_read(16'hEC10);
    io_write(8'hF1, 8'h3F);
    mem_read(16'hFFF3);
    vb = 1'b0;
    io_write(8'hFC, 8'h00);

    repeat (4) @(posedge clk);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
